instruction_decode: RTL

Instruction-decode stage of the 20-bit pipeline, sitting directly upstream of the execute stage.
- Decodes a 16-bit instruction and reads two operands from an 8×20-bit register file.
- Detects RAW hazards against older in-flight instructions and stalls fetch.
- Registers everything the execute stage consumes into the ID/EX pipeline register: ALU control, opA, read-data-2, destination and write-enable.

---
 rtl/pipeline_defs.sv | 19 +
 rtl/register_file.sv | 47 ++++
 rtl/instruction_decode.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipeline_defs.sv
// Shared definitions for the 20-bit pipeline: widths,
// opcodes and ALU control encodings.
package pipeline_defs;

  localparam int DATA_W    = 20;
  localparam int NREGS     = 8;
  localparam int REG_IDX_W = 3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/register_file.sv
// Register file: 2 combinational read ports with write-before-read bypass, 1 write.
// Ports: clock, reset (async low), ra1/ra2 -> rdata1/rdata2, we/wa/wdata.
module register_file
  import pipeline_defs::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREGS,
  parameter int IW = $clog2(NR)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] ra1,
  input  logic [IW-1:0] ra2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs [NR];
  logic          wr_ok;

  // r0 is hardwired: never written, never bypassed.
  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[ra1];
    if (ra1 == '0) rdata1 = '0;
    else if (wr_ok && wa == ra1) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[ra2];
    if (ra2 == '0) rdata2 = '0;
    else if (wr_ok && wa == ra2) rdata2 = wdata;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: decode, register read, RAW hazard stall, ID/EX register.
// Ports: instr/instr_valid/flush in, mem_*/wb_* from later stages, id_stall + ex_* out.
module instruction_decode
  import pipeline_defs::*;
#(
  parameter int DATA_W = pipeline_defs::DATA_W,
  parameter int NREGS  = pipeline_defs::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  input  logic              flush,
  input  logic [2:0]        mem_rd,
  input  logic              mem_regWrite,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_regWrite,
  output logic              id_stall,
  output logic [1:0]        ex_control,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_rfReadData2,
  output logic [2:0]        ex_rd,
  output logic              ex_regWrite,
  output logic              ex_valid
);

  logic [3:0]        opcode;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              is_alu;
  logic              use_rt;
  logic              hit_rs;
  logic              hit_rt;
  logic              bubble;

  assign opcode = instr[15:12];
  assign rd     = instr[11:9];
  assign rs     = instr[8:6];
  assign rt     = instr[5:3];

  register_file #(
    .DW (DATA_W),
    .NR (NREGS),
    .IW (3)
  ) u_rf (
    .clock  (clock),
    .reset  (reset),
    .ra1    (rs),
    .ra2    (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_regWrite),
    .wa     (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    is_alu = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      opcode == OP_ADD,
      opcode == OP_OR,
      opcode == OP_AND: begin
        is_alu = 1'b1;
        use_rt = 1'b1;
      end
      opcode == OP_NOT: is_alu = 1'b1;
      default: ;
    endcase
  end

  function automatic logic src_hit(input logic [2:0] s);
    return (s != 3'd0) &&
           ((ex_valid && ex_regWrite && s == ex_rd) ||
            (mem_regWrite && s == mem_rd));
  endfunction

  assign hit_rs = is_alu && src_hit(rs);
  assign hit_rt = use_rt && src_hit(rt);

  // Gated by reset so the stall is quiet while held in reset.
  assign id_stall = reset && instr_valid && !flush &&
                    (hit_rs || hit_rt);

  assign bubble = flush || id_stall || !instr_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid       <= 1'b0;
      ex_regWrite    <= 1'b0;
      ex_control     <= 2'b00;
      ex_rd          <= 3'd0;
      ex_opA         <= '0;
      ex_rfReadData2 <= '0;
    end else if (bubble) begin
      ex_valid       <= 1'b0;
      ex_regWrite    <= 1'b0;
      ex_control     <= 2'b00;
      ex_rd          <= 3'd0;
      ex_opA         <= '0;
      ex_rfReadData2 <= '0;
    end else begin
      ex_valid       <= 1'b1;
      ex_regWrite    <= is_alu;
      ex_control     <= is_alu ? opcode[1:0] : ALU_ADD;
      ex_rd          <= rd;
      ex_opA         <= rdata1;
      ex_rfReadData2 <= rdata2;
    end
  end

endmodule
